// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, issuer FSM state encoding and a
// helper that says which opcodes the attached ALU actually implements.
// Used by alu_cmd_issuer and by the bench-side ALU model.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   // The ALU only implements ADD, AND, NOT and OR; the rest are reserved codes.
   function automatic logic op_is_impl(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_OR);
   endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// Initiator for a combinational ALU. A command accepted over cmd_valid/ready
// is registered onto the ALU inputs, held for a settle window, and the ALU
// result is captured and returned over rsp_valid/ready. A carry register lets
// chained ADDs build multi-word sums across commands.
//
// Optional feature macro: ALU_ISSUER_ERR_EN
//   defined   -> rsp_err port; reserved opcodes return rsp_err=1, result 0
//   undefined -> no rsp_err; ALU output returned as-is for every opcode
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | cmd_ready=1, waiting for a command
// ST_DRIVE | operands held on the ALU; settle counter runs, then capture
// ST_RESP  | rsp_valid=1, payload held until the consumer takes it
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_opcode,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic             cmd_chain,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
`ifdef ALU_ISSUER_ERR_EN
   output logic             rsp_err,
`endif
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_carry_in,
   input  logic [WIDTH-1:0] alu_output,
   input  logic [WIDTH-1:0] alu_carry_out
);

   // Counter holds SETTLE_CYCLES-1; at least one bit wide.
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   logic [1:0]       state_q,      state_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;
   logic             arm_q,        arm_d;
   logic             carry_q,      carry_d;
   logic [WIDTH-1:0] alu_a_q,      alu_a_d;
   logic [WIDTH-1:0] alu_b_q,      alu_b_d;
   logic [2:0]       alu_op_q,     alu_op_d;
   logic             cin_q,        cin_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_carry_q,  rsp_carry_d;
   logic             rsp_err_q,    rsp_err_d;

   logic             op_is_add;
   logic             op_err;
   logic             unused_carry_hi;

   assign op_is_add = (alu_op_q == OP_ADD);

`ifdef ALU_ISSUER_ERR_EN
   assign op_err = ~op_is_impl(alu_op_q);
`else
   assign op_err = 1'b0;
`endif

   // Only bit 0 of the ALU carry bus carries information.
   assign unused_carry_hi = ^alu_carry_out[WIDTH-1:1];

   // Next-state logic: FSM, settle counter, operand load and result capture.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      arm_d        = arm_q;
      carry_d      = carry_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      cin_d        = cin_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_err_d    = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d  = ST_DRIVE;
               alu_a_d  = cmd_a;
               alu_b_d  = cmd_b;
               alu_op_d = cmd_opcode;
               cin_d    = cmd_chain & carry_q;
               cnt_d    = CNT_LOAD;
               arm_d    = 1'b0;
            end
         end

         ST_DRIVE: begin
            // Terminal count arms the capture; the edge after that samples
            // the ALU, giving SETTLE_CYCLES+1 edges from accept to capture.
            if (arm_q) begin
               state_d = ST_RESP;
               arm_d   = 1'b0;
               if (op_err) begin
                  rsp_result_d = '0;
                  rsp_carry_d  = 1'b0;
                  rsp_err_d    = 1'b1;
               end else begin
                  rsp_result_d = alu_output;
                  rsp_carry_d  = op_is_add & alu_carry_out[0];
                  rsp_err_d    = 1'b0;
               end
               if (op_is_add) begin
                  carry_d = alu_carry_out[0];
               end
            end else if (cnt_q == '0) begin
               arm_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset; reset also aborts
   // any command in flight and forgets the chained carry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         arm_q        <= 1'b0;
         carry_q      <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         cin_q        <= 1'b0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         arm_q        <= arm_d;
         carry_q      <= carry_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         cin_q        <= cin_d;
         rsp_result_q <= rsp_result_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign cmd_ready    = (state_q == ST_IDLE);
   assign rsp_valid    = (state_q == ST_RESP);
   assign rsp_result   = rsp_result_q;
   assign rsp_carry    = rsp_carry_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_opcode   = alu_op_q;
   assign alu_carry_in = {{(WIDTH-1){1'b0}}, cin_q};

`ifdef ALU_ISSUER_ERR_EN
   assign rsp_err = rsp_err_q;
`else
   logic unused_err;
   assign unused_err = rsp_err_q;
`endif

endmodule
